// File: rtl/l2_cache_responder.sv
// Direct-mapped, write-back, write-allocate L2 responder with pmem miss handling.
// Optional hit/miss counters enabled by defining L2_PERF_CNT_EN.
module l2_cache_responder #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              l2_read,
    input  logic              l2_write,
    input  logic [ADDR_W-1:0] l2_address,
    input  logic [LINE_W-1:0] l2_wdata,
    output logic [LINE_W-1:0] l2_rdata,
    output logic              l2_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int TAG_W = ADDR_W - 5 - IDX_W;
    localparam int SETS  = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE} state_t;

    state_t r_state, w_next;

    logic [LINE_W-1:0] r_data [SETS];
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [SETS-1:0]   r_valid;
    logic [SETS-1:0]   r_dirty;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_req_tag;
    logic             w_hit;
    logic             w_wr_hit;
    logic             w_wb_done;
    logic             w_fill;
    logic             w_unused;

    assign w_idx     = l2_address[IDX_W+4:5];
    assign w_req_tag = l2_address[ADDR_W-1:IDX_W+5];
    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_req_tag);
    assign w_unused  = &{1'b0, l2_address[4:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        l2_resp      = 1'b0;
        l2_rdata     = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        w_wr_hit     = 1'b0;
        w_wb_done    = 1'b0;
        w_fill       = 1'b0;
        case (r_state)
            IDLE: begin
                if (l2_read || l2_write) w_next = LOOKUP;
            end
            LOOKUP: begin
                if (w_hit) begin
                    l2_resp = 1'b1;
                    // Read and write both high resolves to a write.
                    if (l2_write) w_wr_hit = 1'b1;
                    else          l2_rdata = r_data[w_idx];
                    w_next = IDLE;
                end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                    w_next = WRITEBACK;
                end else begin
                    w_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_idx], w_idx, 5'b0};
                pmem_wdata   = r_data[w_idx];
                if (pmem_resp) begin
                    w_wb_done = 1'b1;
                    w_next    = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {w_req_tag, w_idx, 5'b0};
                if (pmem_resp) begin
                    w_fill = 1'b1;
                    w_next = LOOKUP;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_wb_done) begin
            r_dirty[w_idx] <= 1'b0;
        end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Line storage is not reset; valid bits alone qualify the contents.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_idx] <= pmem_rdata;
            r_tag[w_idx]  <= w_req_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx] <= l2_wdata;
        end
    end

`ifdef L2_PERF_CNT_EN
    logic        r_post_fill;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // The lookup following a fill always hits; it belongs to the miss already counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_post_fill  <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_fill)                  r_post_fill <= 1'b1;
            else if (r_state == LOOKUP)  r_post_fill <= 1'b0;
            if (r_state == LOOKUP && w_hit && !r_post_fill && r_hit_count != 32'hFFFF_FFFF)
                r_hit_count <= r_hit_count + 32'd1;
            if (r_state == LOOKUP && !w_hit && r_miss_count != 32'hFFFF_FFFF)
                r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_cache_responder.sv
// Directed scoreboard bench for l2_cache_responder with a latency-configurable memory model.
module tb_l2_cache_responder;
    logic         clk;
    logic         rst_n;
    logic         l2_read;
    logic         l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata;
    logic         l2_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    l2_cache_responder dut (
        .clk(clk), .rst_n(rst_n),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    localparam logic [255:0] LINE_A = {8{32'hA5A5_1000}};
    localparam logic [255:0] LINE_B = {8{32'hB0B0_0B0B}};
    localparam logic [255:0] LINE_C = {8{32'hC3C3_3C3C}};
    localparam logic [255:0] LINE_D = {8{32'hD00D_1400}};

    typedef struct { bit wr; logic [255:0] data; } l2_exp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } pm_exp_t;

    l2_exp_t l2exp[$];
    pm_exp_t pexp[$];
    logic [255:0] mem [logic [31:0]];

    int n_chk  = 0;
    int n_fail = 0;
    int mem_lat = 4;
    int mem_cnt = 0;
    bit spurious = 0;
    bit both_seen = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef L2_PERF_CNT_EN
        return v;
`else
        return (v != 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory model and pmem-side checker.
    initial begin
        pm_exp_t e;
        pmem_resp  = 0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) both_seen = 1;
            if (spurious) begin
                pmem_resp  = 1'b1;
                pmem_rdata = {8{32'hDEAD_BEEF}};
                spurious   = 0;
            end else if (!rst_n) begin
                mem_cnt = 0;
            end else if (pmem_read || pmem_write) begin
                if (mem_cnt == 0) begin
                    n_chk++;
                    if (pexp.size() == 0) begin
                        n_fail++;
                        $display("FAIL pmem_unexpected: got rd=%0b wr=%0b addr=%h expected no access",
                                 pmem_read, pmem_write, pmem_address);
                    end
                end
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    mem_cnt = 0;
                    if (pexp.size() > 0) begin
                        e = pexp.pop_front();
                        chk("pmem_write", {255'd0, pmem_write}, {255'd0, e.wr});
                        chk("pmem_address", {224'd0, pmem_address}, {224'd0, e.addr});
                        if (e.wr) chk("pmem_wdata", pmem_wdata, e.data);
                    end
                    if (pmem_write) mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = mem.exists(pmem_address) ? mem[pmem_address] : '0;
                    pmem_resp = 1'b1;
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    // l2 response monitor.
    initial begin
        l2_exp_t e;
        forever begin
            @(negedge clk);
            if (l2_resp) begin
                if (l2exp.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL l2_resp_unexpected: got resp=1 expected none");
                end else begin
                    e = l2exp.pop_front();
                    if (!e.wr) chk("l2_rdata", l2_rdata, e.data);
                    else       chk("l2_resp_write", {255'd0, l2_resp}, 256'd1);
                end
            end
        end
    end

    task automatic do_req(input string nm, input bit wr, input logic [31:0] addr,
                          input logic [255:0] wd, input logic [255:0] exp_rd, input int exp_lat);
        int  cyc;
        bit  done;
        l2_exp_t e;
        @(posedge clk);
        #1;
        l2_read    = !wr;
        l2_write   = wr;
        l2_address = addr;
        l2_wdata   = wd;
        e.wr = wr;
        e.data = exp_rd;
        l2exp.push_back(e);
        cyc  = 0;
        done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (l2_resp) done = 1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no l2_resp in %0d cycles expected %0d", nm, cyc, exp_lat);
        end else begin
            chk({nm, "_latency"}, cyc, exp_lat);
        end
    endtask

    task automatic idle_bus();
        @(posedge clk);
        #1;
        l2_read  = 0;
        l2_write = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic pm_exp_t pm(input bit wr, input logic [31:0] a, input logic [255:0] d);
        pm_exp_t e;
        e.wr = wr;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    initial begin
        rst_n = 0;
        l2_read = 0;
        l2_write = 0;
        l2_address = '0;
        l2_wdata = '0;
        mem[32'h0000_1000] = LINE_A;
        mem[32'h0000_1400] = LINE_D;

        #12;
        chk("rst_l2_resp", {255'd0, l2_resp}, 256'd0);
        chk("rst_pmem_rw", {254'd0, pmem_read, pmem_write}, 256'd0);
        chk("rst_l2_rdata", l2_rdata, 256'd0);
        chk("rst_pmem_address", {224'd0, pmem_address}, 256'd0);
        chk("rst_pmem_wdata", pmem_wdata, 256'd0);
        chk("rst_hit_count", {224'd0, hit_count}, 256'd0);
        chk("rst_miss_count", {224'd0, miss_count}, 256'd0);
        @(posedge clk);
        #1 rst_n = 1;

        // Cold read miss, clean fill.
        pexp.push_back(pm(0, 32'h0000_1000, '0));
        do_req("cold_miss", 0, 32'h0000_1000, '0, LINE_A, 7);
        idle_bus();
        chk("miss_count_1", {224'd0, miss_count}, {224'd0, cnt_exp(1)});
        chk("hit_count_0", {224'd0, hit_count}, {224'd0, cnt_exp(0)});

        // Read hit, low bits of the address ignored.
        do_req("read_hit", 0, 32'h0000_101F, '0, LINE_A, 2);
        idle_bus();
        chk("hit_count_1", {224'd0, hit_count}, {224'd0, cnt_exp(1)});

        // Write hit makes the line dirty, then conflicting read forces writeback.
        do_req("write_hit", 1, 32'h0000_1000, LINE_B, '0, 2);
        idle_bus();
        pexp.push_back(pm(1, 32'h0000_1000, LINE_B));
        pexp.push_back(pm(0, 32'h0000_1400, '0));
        do_req("dirty_miss", 0, 32'h0000_1400, '0, LINE_D, 11);
        idle_bus();
        chk("mem_writeback_B", mem[32'h0000_1000], LINE_B);
        chk("miss_count_2", {224'd0, miss_count}, {224'd0, cnt_exp(2)});

        // Write hit immediately followed by a read on the response edge.
        do_req("b2b_write", 1, 32'h0000_1400, LINE_C, '0, 2);
        pexp.push_back(pm(1, 32'h0000_1400, LINE_C));
        pexp.push_back(pm(0, 32'h0000_1000, '0));
        do_req("b2b_read", 0, 32'h0000_1000, '0, LINE_B, 11);
        idle_bus();
        chk("hit_count_3", {224'd0, hit_count}, {224'd0, cnt_exp(3)});
        chk("miss_count_3", {224'd0, miss_count}, {224'd0, cnt_exp(3)});

        // Reset in the middle of an allocate.
        mem_lat = 20;
        pexp.push_back(pm(0, 32'h0000_2000, '0));
        @(posedge clk);
        #1;
        l2_read = 1;
        l2_address = 32'h0000_2000;
        repeat (4) @(negedge clk);
        chk("alloc_pmem_read", {255'd0, pmem_read}, 256'd1);
        chk("alloc_pmem_address", {224'd0, pmem_address}, {224'd0, 32'h0000_2000});
        #2 rst_n = 0;
        #1;
        chk("async_pmem_read", {255'd0, pmem_read}, 256'd0);
        chk("async_pmem_address", {224'd0, pmem_address}, 256'd0);
        l2_read = 0;
        pexp.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_hit_count", {224'd0, hit_count}, 256'd0);
        chk("rst_mid_miss_count", {224'd0, miss_count}, 256'd0);
        rst_n = 1;
        mem_lat = 4;

        // Valid bits were cleared: the previously cached line misses again.
        pexp.push_back(pm(0, 32'h0000_1000, '0));
        do_req("post_rst_miss", 0, 32'h0000_1000, '0, LINE_B, 7);
        idle_bus();
        chk("post_rst_miss_count", {224'd0, miss_count}, {224'd0, cnt_exp(1)});

        // Stray memory response while idle must be ignored.
        @(posedge clk);
        #1 spurious = 1;
        repeat (4) @(posedge clk);
        #1;
        do_req("after_spurious_hit", 0, 32'h0000_1000, '0, LINE_B, 2);
        idle_bus();
        chk("final_hit_count", {224'd0, hit_count}, {224'd0, cnt_exp(1)});
        chk("final_miss_count", {224'd0, miss_count}, {224'd0, cnt_exp(1)});

        chk("l2exp_drained", l2exp.size(), 0);
        chk("pexp_drained", pexp.size(), 0);
        chk("pmem_rw_exclusive", {255'd0, both_seen}, 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: got simulation still running expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
